vend_controller: RTL and testbench

//  Top-level sequencer for the two-product vending datapath.
//  - Accumulates coin credit and arbitrates between product buttons A and B.
//  - Drives the dispense motor for the selected product and supervises it with a timeout.
//  - Pays remaining credit back as timed unit change pulses.

---
 rtl/vend_controller.sv | 193 +++++++++++++++++++
 tb/tb_vend_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// vend_controller: coin credit accumulation, A/B product arbitration, supervised dispense
// and timed change payout. Optional refund button is enabled by defining REFUND_BTN_EN.
module vend_controller #(
    parameter int unsigned PRICE_A       = 2,
    parameter int unsigned PRICE_B       = 3,
    parameter int unsigned CREDIT_MAX    = 15,
    parameter int unsigned MOTOR_TIMEOUT = 8,
    parameter int unsigned PULSE_LEN     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_val,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       motor_done,
`ifdef REFUND_BTN_EN
    input  logic       refund,
`endif
    output logic       motor_a,
    output logic       motor_b,
    output logic       change_pulse,
    output logic       coin_reject,
    output logic [3:0] credit,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, CREDIT, VEND, CHANGE, ERROR} state_e;

    localparam int unsigned CNT_MAX = (MOTOR_TIMEOUT > PULSE_LEN) ? MOTOR_TIMEOUT : PULSE_LEN;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [3:0]    PA         = 4'(PRICE_A);
    localparam logic [3:0]    PB         = 4'(PRICE_B);
    localparam logic [4:0]    CMAX       = 5'(CREDIT_MAX);
    localparam logic [CW-1:0] VEND_LAST  = CW'(MOTOR_TIMEOUT - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);

    state_e        state_q, state_d;
    logic [3:0]    credit_q, credit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          motor_a_q, motor_a_d;
    logic          motor_b_q, motor_b_d;
    logic          change_pulse_q, change_pulse_d;
    logic          coin_reject_q, coin_reject_d;
    logic          last_sel_q, last_sel_d;   // 1 = product B served last

    logic [3:0] coin_units;
    logic [4:0] coin_sum;
    logic       coin_nz, coin_ok;
    logic       qual_a, qual_b, pick_b, refund_req;
    logic [3:0] vend_price, credit_after;

    always_comb begin
        coin_units = 4'd0;
        case (coin_val)
            2'b01:   coin_units = 4'd2;
            2'b10:   coin_units = 4'd3;
            2'b11:   coin_units = 4'd4;
            default: coin_units = 4'd0;
        endcase
    end

    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_units};
    assign coin_nz  = coin_valid && (coin_val != 2'b00);
    assign coin_ok  = coin_nz && ((state_q == IDLE) || (state_q == CREDIT)) && (coin_sum <= CMAX);

    // Button qualification uses the credit held before any coin arriving this cycle.
    assign qual_a = btn_a && (credit_q >= PA);
    assign qual_b = btn_b && (credit_q >= PB);
    assign pick_b = qual_b && (!qual_a || !last_sel_q);

    assign vend_price   = motor_a_q ? PA : PB;
    assign credit_after = credit_q - vend_price;

`ifdef REFUND_BTN_EN
    assign refund_req = refund;
`else
    assign refund_req = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        cnt_d          = cnt_q;
        motor_a_d      = 1'b0;
        motor_b_d      = 1'b0;
        change_pulse_d = change_pulse_q;
        coin_reject_d  = coin_nz && !coin_ok;
        last_sel_d     = last_sel_q;

        case (state_q)
            IDLE: begin
                change_pulse_d = 1'b0;
                if (coin_ok) begin
                    credit_d = coin_sum[3:0];
                    state_d  = CREDIT;
                end
            end
            CREDIT: begin
                if (coin_ok) credit_d = coin_sum[3:0];
                if (refund_req) begin
                    state_d        = CHANGE;
                    cnt_d          = '0;
                    change_pulse_d = 1'b1;
                end else if (qual_a || qual_b) begin
                    state_d   = VEND;
                    cnt_d     = '0;
                    motor_a_d = !pick_b;
                    motor_b_d = pick_b;
                end
            end
            VEND: begin
                motor_a_d = motor_a_q;
                motor_b_d = motor_b_q;
                if (motor_done) begin
                    motor_a_d  = 1'b0;
                    motor_b_d  = 1'b0;
                    credit_d   = credit_after;
                    last_sel_d = motor_b_q;
                    cnt_d      = '0;
                    if (credit_after != 4'd0) begin
                        state_d        = CHANGE;
                        change_pulse_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == VEND_LAST) begin
                    motor_a_d = 1'b0;
                    motor_b_d = 1'b0;
                    state_d   = ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHANGE: begin
                // Credit drops together with the falling edge of each pulse.
                if (cnt_q != PULSE_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (change_pulse_q) begin
                    cnt_d          = '0;
                    change_pulse_d = 1'b0;
                    if (credit_q != 4'd0) credit_d = credit_q - 4'd1;
                end else if (credit_q == 4'd0) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d          = '0;
                    change_pulse_d = 1'b1;
                end
            end
            ERROR: begin
                change_pulse_d = 1'b0;
            end
            default: begin
                state_d        = IDLE;
                change_pulse_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            cnt_q          <= '0;
            motor_a_q      <= 1'b0;
            motor_b_q      <= 1'b0;
            change_pulse_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            last_sel_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            cnt_q          <= cnt_d;
            motor_a_q      <= motor_a_d;
            motor_b_q      <= motor_b_d;
            change_pulse_q <= change_pulse_d;
            coin_reject_q  <= coin_reject_d;
            last_sel_q     <= last_sel_d;
        end
    end

    assign motor_a      = motor_a_q;
    assign motor_b      = motor_b_q;
    assign change_pulse = change_pulse_q;
    assign coin_reject  = coin_reject_q;
    assign credit       = credit_q;
    assign busy         = (state_q == VEND) || (state_q == CHANGE);
    assign err          = (state_q == ERROR);

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: each stimulus cycle queues the expected output
// vector {motor_a, motor_b, change_pulse, coin_reject, credit, busy, err}.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin_val;
    logic       btn_a, btn_b, motor_done, refund;
    logic       motor_a, motor_b, change_pulse, coin_reject, busy, err;
    logic [3:0] credit;

    always #5 clk = ~clk;

    vend_controller #(
        .PRICE_A(2), .PRICE_B(3), .CREDIT_MAX(15), .MOTOR_TIMEOUT(8), .PULSE_LEN(2)
    ) dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_val(coin_val),
        .btn_a(btn_a), .btn_b(btn_b), .motor_done(motor_done),
`ifdef REFUND_BTN_EN
        .refund(refund),
`endif
        .motor_a(motor_a), .motor_b(motor_b), .change_pulse(change_pulse),
        .coin_reject(coin_reject), .credit(credit), .busy(busy), .err(err)
    );

    localparam logic [2:0] NC = 3'b000;  // {valid, value}
    localparam logic [2:0] C0 = 3'b100;
    localparam logic [2:0] C2 = 3'b101;
    localparam logic [2:0] C3 = 3'b110;
    localparam logic [2:0] C4 = 3'b111;

    string       q_tag[$];
    logic [9:0]  q_exp[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [9:0] obs;
    assign obs = {motor_a, motor_b, change_pulse, coin_reject, credit, busy, err};

    function automatic logic [9:0] o(input logic ma, input logic mb, input logic cp,
                                     input logic rj, input logic [3:0] cr,
                                     input logic bz, input logic er);
        return {ma, mb, cp, rj, cr, bz, er};
    endfunction

    function automatic string fmt(input logic [9:0] v);
        return $sformatf("ma=%0b mb=%0b cp=%0b rej=%0b cr=%0d busy=%0b err=%0b",
                         v[9], v[8], v[7], v[6], v[5:2], v[1], v[0]);
    endfunction

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {%s} expected {%s}", tag, fmt(got), fmt(exp));
        end
    endtask

    task automatic drain();
        while (q_tag.size() > 0) check(q_tag.pop_front(), obs, q_exp.pop_front());
    endtask

    task automatic expect_now(input string tag, input logic [9:0] exp);
        q_tag.push_back(tag);
        q_exp.push_back(exp);
        drain();
    endtask

    task automatic step(input string tag, input logic [2:0] coin, input logic a, input logic b,
                        input logic md, input logic rf, input logic [9:0] exp);
        coin_valid = coin[2];
        coin_val   = coin[1:0];
        btn_a      = a;
        btn_b      = b;
        motor_done = md;
        refund     = rf;
        q_tag.push_back(tag);
        q_exp.push_back(exp);
        @(posedge clk);
        #1;
        coin_valid = 1'b0; coin_val = 2'b00; btn_a = 1'b0; btn_b = 1'b0;
        motor_done = 1'b0; refund = 1'b0;
        drain();
    endtask

    // Asserts reset between edges and checks outputs before the next clock edge.
    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1 expect_now(tag, o(0, 0, 0, 0, 4'd0, 0, 0));
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; coin_valid = 1'b0; coin_val = 2'b00; btn_a = 1'b0; btn_b = 1'b0;
        motor_done = 1'b0; refund = 1'b0;
        @(posedge clk);
        #1;
        do_reset("reset_init");

        // Vend A from credit 4, then two change units of 2 high / 2 low
        step("t1_coin4",  C4, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd4, 0, 0));
        step("t1_btn_a",  NC, 1, 0, 0, 0, o(1, 0, 0, 0, 4'd4, 1, 0));
        step("t1_wait",   NC, 0, 0, 0, 0, o(1, 0, 0, 0, 4'd4, 1, 0));
        step("t1_done",   NC, 0, 0, 1, 0, o(0, 0, 1, 0, 4'd2, 1, 0));
        step("t1_hi1b",   NC, 0, 0, 0, 0, o(0, 0, 1, 0, 4'd2, 1, 0));
        step("t1_lo1a",   NC, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd1, 1, 0));
        step("t1_lo1b",   NC, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd1, 1, 0));
        step("t1_hi2a",   NC, 0, 0, 0, 0, o(0, 0, 1, 0, 4'd1, 1, 0));
        step("t1_hi2b",   NC, 0, 0, 0, 0, o(0, 0, 1, 0, 4'd1, 1, 0));
        step("t1_lo2a",   NC, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd0, 1, 0));
        step("t1_lo2b",   NC, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd0, 1, 0));
        step("t1_idle",   NC, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd0, 0, 0));

        // B below price ignored; button judged on pre-coin credit; coin in VEND rejected
        step("t4_coin2",   C2, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd2, 0, 0));
        step("t4_b_low",   NC, 0, 1, 0, 0, o(0, 0, 0, 0, 4'd2, 0, 0));
        step("t4_b_coin",  C2, 0, 1, 0, 0, o(0, 0, 0, 0, 4'd4, 0, 0));
        step("t4_b_vend",  NC, 0, 1, 0, 0, o(0, 1, 0, 0, 4'd4, 1, 0));
        step("t4_vcoin",   C2, 0, 0, 0, 0, o(0, 1, 0, 1, 4'd4, 1, 0));
        step("t4_done",    NC, 0, 0, 1, 0, o(0, 0, 1, 0, 4'd1, 1, 0));
        step("t4_hi",      NC, 0, 0, 0, 0, o(0, 0, 1, 0, 4'd1, 1, 0));
        step("t4_lo_a",    NC, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd0, 1, 0));
        step("t4_lo_b",    NC, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd0, 1, 0));
        step("t4_idle",    NC, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd0, 0, 0));

        // Ties alternate: last served was B, so A then B
        step("t2_coin3",   C3, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd3, 0, 0));
        step("t2_tie1",    NC, 1, 1, 0, 0, o(1, 0, 0, 0, 4'd3, 1, 0));
        step("t2_done1",   NC, 0, 0, 1, 0, o(0, 0, 1, 0, 4'd1, 1, 0));
        step("t2_hi",      NC, 0, 0, 0, 0, o(0, 0, 1, 0, 4'd1, 1, 0));
        step("t2_lo_a",    NC, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd0, 1, 0));
        step("t2_lo_b",    NC, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd0, 1, 0));
        step("t2_idle",    NC, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd0, 0, 0));
        step("t2_coin3b",  C3, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd3, 0, 0));
        step("t2_tie2",    NC, 1, 1, 0, 0, o(0, 1, 0, 0, 4'd3, 1, 0));
        step("t2_done2",   NC, 0, 0, 1, 0, o(0, 0, 0, 0, 4'd0, 0, 0));

        // motor_done on the last allowed VEND cycle still completes the vend
        step("tl_coin2",   C2, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd2, 0, 0));
        step("tl_btn_a",   NC, 1, 0, 0, 0, o(1, 0, 0, 0, 4'd2, 1, 0));
        for (int i = 0; i < 7; i++)
            step("tl_wait", NC, 0, 0, 0, 0, o(1, 0, 0, 0, 4'd2, 1, 0));
        step("tl_done",    NC, 0, 0, 1, 0, o(0, 0, 0, 0, 4'd0, 0, 0));

        // Credit saturation by rejection
        step("t3_c4a",     C4, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd4,  0, 0));
        step("t3_c4b",     C4, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd8,  0, 0));
        step("t3_c3",      C3, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd11, 0, 0));
        step("t3_c2",      C2, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd13, 0, 0));
        step("t3_rej16",   C3, 0, 0, 0, 0, o(0, 0, 0, 1, 4'd13, 0, 0));
        step("t3_after",   NC, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd13, 0, 0));
        step("t3_val00",   C0, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd13, 0, 0));
        step("t3_to15",    C2, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd15, 0, 0));
        step("t3_rej17",   C2, 0, 0, 0, 0, o(0, 0, 0, 1, 4'd15, 0, 0));
        do_reset("t3_reset");

        // Motor timeout -> ERROR, sticky until reset
        step("t5_coin3",   C3, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd3, 0, 0));
        step("t5_btn_b",   NC, 0, 1, 0, 0, o(0, 1, 0, 0, 4'd3, 1, 0));
        for (int i = 0; i < 7; i++)
            step("t5_wait", NC, 0, 0, 0, 0, o(0, 1, 0, 0, 4'd3, 1, 0));
        step("t5_timeout", NC, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd3, 0, 1));
        step("t5_ignore",  C4, 1, 1, 0, 0, o(0, 0, 0, 1, 4'd3, 0, 1));
        step("t5_late_md", NC, 0, 0, 1, 0, o(0, 0, 0, 0, 4'd3, 0, 1));
        do_reset("t5_reset");

        // Reset in the middle of a change pulse
        step("t6_coin4",   C4, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd4, 0, 0));
        step("t6_btn_a",   NC, 1, 0, 0, 0, o(1, 0, 0, 0, 4'd4, 1, 0));
        step("t6_done",    NC, 0, 0, 1, 0, o(0, 0, 1, 0, 4'd2, 1, 0));
        do_reset("t6_rst_mid");
        step("t6_idle",    NC, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd0, 0, 0));

        // After reset the first tie goes to A
        step("t7_coin3",   C3, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd3, 0, 0));
        step("t7_tie",     NC, 1, 1, 0, 0, o(1, 0, 0, 0, 4'd3, 1, 0));
        do_reset("t7_reset");

`ifdef REFUND_BTN_EN
        // Refund beats a qualifying button and pays out all 4 units
        step("rf_coin4",   C4, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd4, 0, 0));
        step("rf_req",     NC, 1, 0, 0, 1, o(0, 0, 1, 0, 4'd4, 1, 0));
        for (int u = 4; u >= 1; u--) begin
            step("rf_hi",  NC, 0, 0, 0, 0, o(0, 0, 1, 0, 4'(u),     1, 0));
            step("rf_lo1", NC, 0, 0, 0, 0, o(0, 0, 0, 0, 4'(u - 1), 1, 0));
            step("rf_lo2", NC, 0, 0, 0, 0, o(0, 0, 0, 0, 4'(u - 1), 1, 0));
            if (u > 1)
                step("rf_next", NC, 0, 0, 0, 0, o(0, 0, 1, 0, 4'(u - 1), 1, 0));
            else
                step("rf_idle", NC, 0, 0, 0, 0, o(0, 0, 0, 0, 4'd0, 0, 0));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
